// File: rtl/wb_classic_to_pipelined_bridge.sv
// Bridges a Wishbone classic master onto a Wishbone pipelined slave: one strobe per
// request, registered request/response paths, and a timeout that forces ERR on a dead slave.
module wb_classic_to_pipelined_bridge #(
  parameter int unsigned AW          = 28,
  parameter int unsigned DW          = 32,
  parameter int unsigned TIMEOUT_CYC = 1024
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [AW-1:0]   wbc_adr,
  input  logic [DW-1:0]   wbc_dat_w,
  output logic [DW-1:0]   wbc_dat_r,
  input  logic [DW/8-1:0] wbc_sel,
  input  logic            wbc_cyc,
  input  logic            wbc_stb,
  input  logic            wbc_we,
  output logic            wbc_ack,
  output logic            wbc_err,
  output logic [AW-1:0]   wbp_adr,
  output logic [DW-1:0]   wbp_dat_w,
  input  logic [DW-1:0]   wbp_dat_r,
  output logic [DW/8-1:0] wbp_sel,
  output logic            wbp_cyc,
  output logic            wbp_stb,
  output logic            wbp_we,
  input  logic            wbp_stall,
  input  logic            wbp_ack,
  input  logic            wbp_err,
  output logic            timeout_o
);

  localparam int unsigned SW = DW / 8;
  localparam int unsigned CW = $clog2(TIMEOUT_CYC);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [AW-1:0]   adr_d;
  logic [DW-1:0]   dat_w_d;
  logic [SW-1:0]   sel_d;
  logic            we_d;
  logic            cyc_d;
  logic            stb_d;
  logic [DW-1:0]   dat_r_d;
  logic            ack_d;
  logic            err_d;
  logic            tmo_d;
  logic            resp_c;
  logic            cnt_last_c;
  logic            accepted;

  assign resp_c     = wbp_ack | wbp_err;
  assign cnt_last_c = (cnt_q == CW'(TIMEOUT_CYC - 1));

  // State and every output are registered here.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      wbp_adr   <= '0;
      wbp_dat_w <= '0;
      wbp_sel   <= '0;
      wbp_we    <= 1'b0;
      wbp_cyc   <= 1'b0;
      wbp_stb   <= 1'b0;
      wbc_dat_r <= '0;
      wbc_ack   <= 1'b0;
      wbc_err   <= 1'b0;
      timeout_o <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      wbp_adr   <= adr_d;
      wbp_dat_w <= dat_w_d;
      wbp_sel   <= sel_d;
      wbp_we    <= we_d;
      wbp_cyc   <= cyc_d;
      wbp_stb   <= stb_d;
      wbc_dat_r <= dat_r_d;
      wbc_ack   <= ack_d;
      wbc_err   <= err_d;
      timeout_o <= tmo_d;
    end
  end

  // Next state and next register values.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    adr_d    = wbp_adr;
    dat_w_d  = wbp_dat_w;
    sel_d    = wbp_sel;
    we_d     = wbp_we;
    cyc_d    = wbp_cyc;
    stb_d    = wbp_stb;
    dat_r_d  = wbc_dat_r;
    ack_d    = 1'b0;
    err_d    = 1'b0;
    tmo_d    = 1'b0;
    accepted = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (wbc_cyc && wbc_stb) begin
          adr_d   = wbc_adr;
          dat_w_d = wbc_dat_w;
          sel_d   = wbc_sel;
          we_d    = wbc_we;
          cyc_d   = 1'b1;
          stb_d   = 1'b1;
          cnt_d   = '0;
          state_d = REQ;
        end
      end

      REQ, WAIT: begin
        if (!wbc_cyc) begin
          cyc_d   = 1'b0;
          stb_d   = 1'b0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + CW'(1);
          // A response only counts once the strobe has been taken by the slave.
          accepted = (state_q == WAIT) || !wbp_stall;
          if (state_q == REQ && !wbp_stall) begin
            stb_d   = 1'b0;
            state_d = WAIT;
          end
          if (accepted && resp_c) begin
            cyc_d   = 1'b0;
            stb_d   = 1'b0;
            ack_d   = !wbp_err;
            err_d   = wbp_err;
            if (!wbp_we) begin
              dat_r_d = wbp_dat_r;
            end
            state_d = RESP;
          end else if (cnt_last_c) begin
            cyc_d   = 1'b0;
            stb_d   = 1'b0;
            err_d   = 1'b1;
            tmo_d   = 1'b1;
            state_d = RESP;
          end
        end
      end

      RESP: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule
